// File: rtl/wrr_arb_pkg.sv
// Shared definitions for the weighted round-robin arbiter: FSM encodings and
// default sizing constants.
package wrr_arb_pkg;

    localparam int DEF_N  = 4;
    localparam int DEF_WW = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker: first set request bit at or above
// ptr, wrapping from N-1 back to 0.
module rr_pick
    import wrr_arb_pkg::*;
#(
    parameter int N   = DEF_N,
    parameter int IDW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]   request,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   onehot,
    output logic [IDW-1:0] id,
    output logic           any
);

    always_comb begin
        int j;
        j      = 0;
        onehot = '0;
        id     = '0;
        any    = 1'b0;
        for (int k = 0; k < N; k++) begin
            // ptr is always < N, so one subtraction is enough to wrap
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            if (!any && request[j]) begin
                onehot[j] = 1'b1;
                id        = IDW'(j);
                any       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter: each owner keeps a registered grant for up to
// weight transfers, then priority rotates past it.
module wrr_arbiter
    import wrr_arb_pkg::*;
#(
    parameter int N   = DEF_N,
    parameter int WW  = DEF_WW,
    parameter int IDW = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    request,
    input  logic [N*WW-1:0] weight,
    input  logic            ready,
    output logic [N-1:0]    grant,
    output logic            grant_valid,
    output logic [IDW-1:0]  grant_id
);

    state_e         state, state_n;
    logic [IDW-1:0] ptr, ptr_n, nxt_ptr, pick_ptr, pick_id, id_n;
    logic [WW-1:0]  credit, credit_n, pick_w, load_credit;
    logic [N-1:0]   pick_oh, grant_n;
    logic           pick_any, xfer, keep, release_turn, load, drop, gv_n;

    assign xfer         = (state == ST_GRANT) && ready;
    assign keep         = (credit > WW'(1)) && |(request & grant);
    assign release_turn = xfer && !keep;
    assign nxt_ptr      = (int'(grant_id) == N - 1) ? '0 : grant_id + IDW'(1);

    // On release the re-pick already uses the rotated pointer, so the old
    // owner ranks last and the handoff costs no idle cycle.
    assign pick_ptr = release_turn ? nxt_ptr : ptr;

    rr_pick #(.N(N), .IDW(IDW)) u_pick (
        .request (request),
        .ptr     (pick_ptr),
        .onehot  (pick_oh),
        .id      (pick_id),
        .any     (pick_any)
    );

    assign pick_w      = weight[int'(pick_id)*WW +: WW];
    assign load_credit = (pick_w == '0) ? WW'(1) : pick_w;

    assign load = ((state == ST_IDLE) || release_turn) && pick_any;
    assign drop = release_turn && !pick_any;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            ptr         <= '0;
            credit      <= '0;
            grant       <= '0;
            grant_valid <= 1'b0;
            grant_id    <= '0;
        end else begin
            state       <= state_n;
            ptr         <= ptr_n;
            credit      <= credit_n;
            grant       <= grant_n;
            grant_valid <= gv_n;
            grant_id    <= id_n;
        end
    end

    always_comb begin
        state_n  = state;
        ptr_n    = ptr;
        credit_n = credit;
        if (release_turn) ptr_n = nxt_ptr;
        if (load) begin
            state_n  = ST_GRANT;
            credit_n = load_credit;
        end else if (drop) begin
            state_n  = ST_IDLE;
            credit_n = '0;
        end else if (xfer) begin
            credit_n = credit - WW'(1);
        end
    end

    always_comb begin
        grant_n = grant;
        id_n    = grant_id;
        if (load) begin
            grant_n = pick_oh;
            id_n    = pick_id;
        end else if (drop) begin
            grant_n = '0;
            id_n    = '0;
        end
        gv_n = |grant_n;
    end

endmodule
